// File: rtl/ram_burst_reader_pkg.sv
// Shared constants and FSM encoding for the RAM burst reader.
// RAM read latency, capture point and output buffer depth live here so the top and FIFO agree.
package ram_burst_reader_pkg;

  localparam int RD_LATENCY    = 3;
  localparam int CAPTURE_DELAY = RD_LATENCY + 1;
  localparam int FIFO_DEPTH    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rd_credit_fifo.sv
// Output buffer for the burst reader: synchronous FIFO whose head word and valid flag are
// registered, plus an occupancy count used for read-credit accounting.
module rd_credit_fifo
  import ram_burst_reader_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [PW:0]      count_n;
  logic             do_push, do_pop;

  assign do_pop   = pop && out_valid;
  assign do_push  = push && ((count != (PW+1)'(DEPTH)) || do_pop);
  assign rd_ptr_n = rd_ptr + PW'(do_pop);
  assign wr_ptr_n = wr_ptr + PW'(do_push);
  assign count_n  = count + (PW+1)'(do_push) - (PW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // The head register is loaded with whatever will sit at rd_ptr_n after this edge,
  // bypassing the array when the incoming word lands directly at the head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      rd_ptr    <= rd_ptr_n;
      wr_ptr    <= wr_ptr_n;
      count     <= count_n;
      out_valid <= (count_n != '0);
      if (count_n == '0)
        out_data <= '0;
      else if (do_push && (rd_ptr_n == wr_ptr))
        out_data <= push_data;
      else
        out_data <= mem[rd_ptr_n];
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Streams a burst of consecutive RAM words (3-cycle read latency) out on a valid/ready port.
// Optional BURST_READER_ABORT_EN adds an abort input that cancels a running burst.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing one read address per cycle while credit allows
// DRAIN | all addresses issued, waiting for the last word to leave
module ram_burst_reader
  import ram_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   burst_len,
`ifdef BURST_READER_ABORT_EN
  input  logic                  abort,
`endif
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dob,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(CAPTURE_DELAY + 1);
  localparam int SW = CW + 1;
  localparam logic [ADDR_WIDTH:0] LEN_ONE = 1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [ADDR_WIDTH:0]     remaining;
  logic                    empty_burst;
  logic [CAPTURE_DELAY-1:0] sr_valid, sr_last;
  logic [IW-1:0]           inflight;
  logic [CW-1:0]           fifo_count;
  logic [DATA_WIDTH:0]     fifo_data;
  logic                    issue, fire, flush;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < CAPTURE_DELAY; i++) inflight = inflight + IW'(sr_valid[i]);
  end

`ifdef BURST_READER_ABORT_EN
  assign flush = abort && busy;
`else
  assign flush = 1'b0;
`endif

  // Issuing is gated by words in flight plus words buffered, so the FIFO can never overflow.
  assign issue = (state == ISSUE) &&
                 ((SW'(inflight) + SW'(fifo_count)) < SW'(FIFO_DEPTH));
  assign fire  = m_tvalid && m_tready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      addrb       <= '0;
      next_addr   <= '0;
      remaining   <= '0;
      empty_burst <= 1'b0;
      sr_valid    <= '0;
      sr_last     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done     <= 1'b0;
      sr_valid <= {sr_valid[CAPTURE_DELAY-2:0], issue};
      sr_last  <= {sr_last[CAPTURE_DELAY-2:0], issue && (remaining == LEN_ONE)};
      if (issue) begin
        addrb     <= next_addr;
        next_addr <= next_addr + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_ONE;
      end
      case (state)
        IDLE: begin
          if (start) begin
            next_addr   <= base_addr;
            remaining   <= burst_len;
            busy        <= 1'b1;
            empty_burst <= (burst_len == '0);
            state       <= (burst_len == '0) ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (issue && (remaining == LEN_ONE)) state <= DRAIN;
        end
        DRAIN: begin
          if (empty_burst || (fire && m_tlast)) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            empty_burst <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (flush) begin
        state       <= IDLE;
        busy        <= 1'b0;
        done        <= 1'b1;
        empty_burst <= 1'b0;
        sr_valid    <= '0;
        sr_last     <= '0;
      end
    end
  end

  rd_credit_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (sr_valid[CAPTURE_DELAY-1]),
    .push_data ({sr_last[CAPTURE_DELAY-1], dob}),
    .pop       (fire),
    .out_valid (m_tvalid),
    .out_data  (fifo_data),
    .count     (fifo_count)
  );

  assign m_tdata = fifo_data[DATA_WIDTH-1:0];
  assign m_tlast = fifo_data[DATA_WIDTH];

endmodule

// File: tb/tb_ram_burst_reader.sv
// Bench for ram_burst_reader: 3-cycle RAM model, queue-based expected word stream,
// directed and randomized bursts, zero-length, reset and optional abort cases.
module tb_ram_burst_reader;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   burst_len = '0;
  logic [AW-1:0] addrb;
  logic [DW-1:0] dob;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic          busy;
  logic          done;
`ifdef BURST_READER_ABORT_EN
  logic          abort = 1'b0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] p1, p2;

  always #5 clk = ~clk;

  // RAM read port: data for an address appears on dob three edges after addrb changes.
  always @(posedge clk) begin
    p1  <= ram[addrb];
    p2  <= p1;
    dob <= p2;
  end

  ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .burst_len (burst_len),
`ifdef BURST_READER_ABORT_EN
    .abort     (abort),
`endif
    .addrb     (addrb),
    .dob       (dob),
    .m_tdata   (m_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tlast   (m_tlast),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_burst(input int base, input int len, input bit rnd_ready, input bit chk_timing);
    logic [DW-1:0] q[$];
    int cyc, got, first_valid, last_xfer;
    bit done_seen, rdy, prev_hold;
    logic [DW-1:0] prev_data;
    logic prev_last;
    for (int i = 0; i < len; i++) q.push_back(ram[(base + i) % DEPTH]);
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); burst_len = (AW+1)'(len); m_tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    cyc = 0; got = 0; first_valid = -1; last_xfer = -1;
    done_seen = 0; prev_hold = 0; prev_data = '0; prev_last = 1'b0;
    while (!done_seen && cyc < 3000) begin
      if (cyc == 2) begin
        start = 1'b1; base_addr = AW'($urandom); burst_len = (AW+1)'($urandom_range(1, 256));
      end
      if (cyc == 3) start = 1'b0;
      check("occupancy_le_8", 64'(dut.u_fifo.count <= 8), 1);
      if (prev_hold) begin
        check("hold_valid", m_tvalid, 1);
        check("hold_data", m_tdata, prev_data);
        check("hold_last", m_tlast, prev_last);
      end
      if (done) begin
        done_seen = 1;
        check("done_after_last", cyc, last_xfer + 1);
        check("busy_clear", busy, 0);
      end
      if (m_tvalid && first_valid < 0) first_valid = cyc;
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_tready = rdy;
      if (m_tvalid && rdy) begin
        if (q.size() == 0) check("extra_word", m_tvalid, 0);
        else begin
          check("data", m_tdata, q.pop_front());
          check("tlast", m_tlast, q.size() == 0);
        end
        got++;
        last_xfer = cyc;
      end
      prev_hold = m_tvalid && !rdy;
      prev_data = m_tdata;
      prev_last = m_tlast;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done_seen, 1);
    check("word_count", got, len);
    if (chk_timing) begin
      check("first_valid_latency", first_valid, 5);
      check("no_bubbles", last_xfer, first_valid + len - 1);
    end
    m_tready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("idle_quiet", m_tvalid, 0);
    end
  endtask

  // Starts a burst and returns once `n` words have been accepted (bounded).
  task automatic start_and_take(input int base, input int len, input int n);
    int got, cyc;
    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); burst_len = (AW+1)'(len); m_tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0; cyc = 0;
    while (got < n && cyc < 100) begin
      if (m_tvalid) begin
        check("partial_data", m_tdata, ram[(base + got) % DEPTH]);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("partial_reached", got, n);
  endtask

  initial begin
    int b, l;
    bit m;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addrb", addrb, 0);
    check("rst_tdata", m_tdata, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_burst(8'h10, 4, 0, 1);
    run_burst(8'hFE, 4, 0, 1);

    // zero-length burst, with a second start while it is still busy
    @(negedge clk);
    start = 1'b1; base_addr = 8'h33; burst_len = '0;
    @(negedge clk);
    base_addr = 8'h40; burst_len = 9'd5;
    check("zl_busy", busy, 1);
    check("zl_done_early", done, 0);
    check("zl_tvalid0", m_tvalid, 0);
    @(negedge clk);
    start = 1'b0;
    check("zl_done", done, 1);
    check("zl_busy_clear", busy, 0);
    check("zl_tvalid1", m_tvalid, 0);
    repeat (10) begin
      @(negedge clk);
      check("zl_quiet_valid", m_tvalid, 0);
      check("zl_quiet_busy", busy, 0);
      check("zl_quiet_done", done, 0);
    end

    run_burst(8'h00, 256, 0, 1);
    run_burst(int'($urandom_range(0, 255)), 256, 1, 0);

    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    for (int k = 0; k < 8; k++) begin
      b = int'($urandom_range(0, 255));
      l = int'($urandom_range(1, 40));
      m = 1'($urandom_range(0, 1));
      run_burst(b, l, m, !m);
    end

    // reset mid-burst after word 3 of 16
    start_and_take(int'($urandom_range(0, 255)), 16, 3);
    check("pre_reset_valid", m_tvalid, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tdata", m_tdata, 0);
    check("mid_rst_tlast", m_tlast, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addrb", addrb, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_quiet", m_tvalid, 0);
    end
    run_burst(int'($urandom_range(0, 255)), 16, 0, 1);

`ifdef BURST_READER_ABORT_EN
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_done", done, 0);
    check("idle_abort_busy", busy, 0);
    start_and_take(int'($urandom_range(0, 255)), 32, 5);
    abort = 1'b1;
    m_tready = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check("abort_tvalid", m_tvalid, 0);
    check("abort_tlast", m_tlast, 0);
    check("abort_done", done, 1);
    check("abort_busy", busy, 0);
    m_tready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("abort_quiet_valid", m_tvalid, 0);
      check("abort_quiet_last", m_tlast, 0);
    end
    run_burst(int'($urandom_range(0, 255)), 12, 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
